// File: rtl/mmss_counter.sv
// Minutes:seconds BCD up/down counter driven by a clk-cycle prescaler, with
// validated preset load, lap (display hold), rollover and sticky expiry flags.
module mmss_counter #(
    parameter int CLK_FREQ = 100000000,
    parameter int MAX_MIN  = 59
) (
    input  logic        clk,
    input  logic        init_regs_n,
    input  logic        count_enabled,
    input  logic        count_down,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        lap,
    output logic [15:0] time_reading,
    output logic        tick,
    output logic        rollover,
    output logic        expired
);

    localparam int            PW        = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
    localparam logic [3:0]    MAX_MT    = 4'(MAX_MIN / 10);
    localparam logic [3:0]    MAX_MO    = 4'(MAX_MIN % 10);
    localparam logic [15:0]   CNT_MAX   = {MAX_MT, MAX_MO, 4'h5, 4'h9};

    logic [PW-1:0] presc, presc_d;
    logic [15:0]   cnt, cnt_d, disp_d;
    logic          hold, hold_d, lap_q;
    logic          tick_d, roll_d, exp_d;
    logic          step, lap_rise;

    function automatic logic preset_ok(input logic [15:0] p);
        int mins;
        mins = int'(p[15:12]) * 10 + int'(p[11:8]);
        return (p[15:12] <= 4'd9) && (p[11:8] <= 4'd9) && (p[7:4] <= 4'd5) &&
               (p[3:0] <= 4'd9) && (mins <= MAX_MIN);
    endfunction

    function automatic logic [15:0] step_up(input logic [15:0] c);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = c;
        if (so != 4'd9) begin
            so = so + 4'd1;
        end else begin
            so = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mt == MAX_MT && mo == MAX_MO) begin
                    mt = 4'd0;
                    mo = 4'd0;
                end else if (mo != 4'd9) begin
                    mo = mo + 4'd1;
                end else begin
                    mo = 4'd0;
                    mt = mt + 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Counting down from 00:00 (only reachable before any expiry) wraps to MAX_MIN:59.
    function automatic logic [15:0] step_dn(input logic [15:0] c);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = c;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else if (mt != 4'd0) begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end else begin
                    mt = MAX_MT;
                    mo = MAX_MO;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    always_comb begin
        lap_rise = lap & ~lap_q;
        step     = count_enabled & (presc == PRESC_MAX);
        presc_d  = presc;
        cnt_d    = cnt;
        hold_d   = hold ^ lap_rise;
        tick_d   = 1'b0;
        roll_d   = 1'b0;
        exp_d    = expired;
        if (count_enabled) begin
            presc_d = step ? '0 : presc + PW'(1);
        end
        if (load) begin
            cnt_d   = preset_ok(preset) ? preset : 16'h0000;
            presc_d = '0;
            exp_d   = 1'b0;
            hold_d  = 1'b0;
        end else if (step && !expired) begin
            tick_d = 1'b1;
            if (count_down) begin
                cnt_d = step_dn(cnt);
                exp_d = (cnt == 16'h0001);
            end else begin
                cnt_d  = step_up(cnt);
                roll_d = (cnt == CNT_MAX);
            end
        end
        // Entering hold captures this edge's count; leaving it shows the live count.
        disp_d = (hold && hold_d) ? time_reading : cnt_d;
    end

    always_ff @(posedge clk or negedge init_regs_n) begin
        if (!init_regs_n) begin
            presc        <= '0;
            cnt          <= 16'h0000;
            hold         <= 1'b0;
            lap_q        <= 1'b0;
            time_reading <= 16'h0000;
            tick         <= 1'b0;
            rollover     <= 1'b0;
            expired      <= 1'b0;
        end else begin
            presc        <= presc_d;
            cnt          <= cnt_d;
            hold         <= hold_d;
            lap_q        <= lap;
            time_reading <= disp_d;
            tick         <= tick_d;
            rollover     <= roll_d;
            expired      <= exp_d;
        end
    end

endmodule

// File: tb/tb_mmss_counter.sv
// Bench for mmss_counter: integer-seconds reference model feeding a scoreboard,
// a preset-validation vector table, and hand-written multi-cycle sequences.
module tb_mmss_counter;

    localparam int CF    = 10;
    localparam int MM    = 59;
    localparam int TOTAL = (MM + 1) * 60;

    logic        clk, init_regs_n, count_enabled, count_down, load, lap;
    logic [15:0] preset, time_reading;
    logic        tick, rollover, expired;

    mmss_counter #(.CLK_FREQ(CF), .MAX_MIN(MM)) dut (
        .clk          (clk),
        .init_regs_n  (init_regs_n),
        .count_enabled(count_enabled),
        .count_down   (count_down),
        .load         (load),
        .preset       (preset),
        .lap          (lap),
        .time_reading (time_reading),
        .tick         (tick),
        .rollover     (rollover),
        .expired      (expired)
    );

    typedef struct packed {
        logic [15:0] tr;
        logic        tk;
        logic        ro;
        logic        ex;
    } obs_t;

    typedef struct packed {
        logic [15:0] pre;
        logic [15:0] want;
    } vec_t;

    obs_t  sb_q[$];
    vec_t  vecs[14];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";
    int    m_secs, m_presc, m_held;
    logic  m_exp, m_hold, m_lap_prev;
    int    tick_seen, ro_seen, cyc_idx, last_tick_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int s);
        int mi, se;
        mi = s / 60;
        se = s % 60;
        return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        return int'(b[15:12]) * 600 + int'(b[11:8]) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic cycle(input logic en, input logic dn, input logic ld,
                         input logic [15:0] pre, input int ld_secs, input logic lp);
        obs_t want, got;
        logic lap_rise, stp;
        count_enabled = en;
        count_down    = dn;
        load          = ld;
        preset        = pre;
        lap           = lp;
        lap_rise   = lp && !m_lap_prev;
        m_lap_prev = lp;
        want.tk = 1'b0;
        want.ro = 1'b0;
        if (ld) begin
            m_secs  = ld_secs;
            m_presc = 0;
            m_exp   = 1'b0;
            m_hold  = 1'b0;
        end else begin
            stp = en && (m_presc == CF - 1);
            if (en) m_presc = (m_presc + 1) % CF;
            if (stp && !m_exp) begin
                want.tk = 1'b1;
                if (dn) begin
                    m_secs = (m_secs == 0) ? TOTAL - 1 : m_secs - 1;
                    if (m_secs == 0) m_exp = 1'b1;
                end else begin
                    m_secs = (m_secs + 1) % TOTAL;
                    if (m_secs == 0) want.ro = 1'b1;
                end
            end
            if (lap_rise) begin
                if (m_hold) begin
                    m_hold = 1'b0;
                end else begin
                    m_hold = 1'b1;
                    m_held = m_secs;
                end
            end
        end
        want.ex = m_exp;
        want.tr = to_bcd(m_hold ? m_held : m_secs);
        sb_q.push_back(want);

        @(posedge clk);
        #1;
        cyc_idx++;
        got = {time_reading, tick, rollover, expired};
        if (tick) begin
            tick_seen++;
            last_tick_cyc = cyc_idx;
        end
        if (rollover) ro_seen++;
        want = sb_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got reading=%h tick=%b rollover=%b expired=%b, expected reading=%h tick=%b rollover=%b expired=%b",
                     phase, cyc_idx, got.tr, got.tk, got.ro, got.ex, want.tr, want.tk, want.ro, want.ex);
        end
    endtask

    task automatic run(input int n, input logic en, input logic dn);
        for (int i = 0; i < n; i++) cycle(en, dn, 1'b0, 16'h0000, 0, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] pre, input logic [15:0] want_bcd,
                           input logic en, input logic dn);
        cycle(en, dn, 1'b1, pre, from_bcd(want_bcd), 1'b0);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge arrives.
    task automatic do_reset();
        #2;
        init_regs_n   = 1'b0;
        lap           = 1'b0;
        load          = 1'b0;
        #1;
        check({phase, " async clear"}, {13'd0, time_reading, tick, rollover, expired}, 32'd0);
        m_secs     = 0;
        m_presc    = 0;
        m_exp      = 1'b0;
        m_hold     = 1'b0;
        m_lap_prev = 1'b0;
        @(posedge clk);
        #3;
        init_regs_n = 1'b1;
    endtask

    initial begin
        init_regs_n   = 1'b1;
        count_enabled = 1'b0;
        count_down    = 1'b0;
        load          = 1'b0;
        preset        = 16'h0000;
        lap           = 1'b0;
        m_secs = 0; m_presc = 0; m_held = 0;
        m_exp = 1'b0; m_hold = 1'b0; m_lap_prev = 1'b0;
        tick_seen = 0; ro_seen = 0; cyc_idx = 0; last_tick_cyc = 0;

        vecs = '{'{16'h1234, 16'h1234}, '{16'h0A00, 16'h0000},
                 '{16'h5959, 16'h5959}, '{16'h6000, 16'h0000},
                 '{16'h0905, 16'h0905}, '{16'h0060, 16'h0000},
                 '{16'h0059, 16'h0059}, '{16'h000A, 16'h0000},
                 '{16'h5958, 16'h5958}, '{16'hF000, 16'h0000},
                 '{16'h1234, 16'h1234}, '{16'h5A00, 16'h0000},
                 '{16'h0901, 16'h0901}, '{16'h0960, 16'h0000}};

        phase = "reset";
        do_reset();

        phase = "up1200";
        tick_seen = 0;
        ro_seen   = 0;
        run(1200, 1'b1, 1'b0);
        check("up1200 tick count", tick_seen, 120);
        check("up1200 rollover count", ro_seen, 0);
        check("up1200 final reading", time_reading, 16'h0200);

        phase = "preset_table";
        foreach (vecs[i]) do_load(vecs[i].pre, vecs[i].want, 1'b0, 1'b0);

        phase = "rollover";
        do_load(16'h5958, 16'h5958, 1'b0, 1'b0);
        ro_seen = 0;
        run(20, 1'b1, 1'b0);
        check("rollover pulse count", ro_seen, 1);
        check("rollover final reading", time_reading, 16'h0000);

        phase = "down_expire";
        do_load(16'h0002, 16'h0002, 1'b0, 1'b1);
        run(20, 1'b1, 1'b1);
        check("expired after 0001->0000", expired, 1);
        tick_seen = 0;
        run(50, 1'b1, 1'b1);
        check("ticks while expired", tick_seen, 0);
        do_load(16'h0010, 16'h0010, 1'b1, 1'b1);
        check("load clears expired", expired, 0);
        run(20, 1'b1, 1'b1);
        check("down after reload", time_reading, 16'h0008);

        phase = "pause";
        do_load(16'h0100, 16'h0100, 1'b0, 1'b0);
        cyc_idx       = 0;
        last_tick_cyc = 0;
        for (int k = 1; k <= 50; k++) cycle(!(k >= 5 && k <= 41), 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        check("paused step cycle", last_tick_cyc, 47);
        check("paused step value", time_reading, 16'h0101);
        run(7, 1'b1, 1'b0);

        phase = "lap";
        do_load(16'h0010, 16'h0010, 1'b0, 1'b0);
        for (int k = 1; k <= 57; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 16'h0000, 0, (k == 23) || (k == 54) || (k == 56));
            if (k == 53) check("lap held reading", time_reading, 16'h0012);
            if (k == 54) check("lap release reading", time_reading, 16'h0015);
        end
        do_load(16'h0A00, 16'h0000, 1'b0, 1'b0);
        check("invalid preset while held", time_reading, 16'h0000);
        run(10, 1'b1, 1'b0);
        check("hold cleared by load", time_reading, 16'h0001);

        phase = "async_reset";
        do_load(16'h0000, 16'h0000, 1'b0, 1'b0);
        run(335, 1'b1, 1'b0);
        check("reading before reset", time_reading, 16'h0033);
        do_reset();
        run(12, 1'b1, 1'b0);
        check("first step after mid-second reset", time_reading, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmss_counter.md
MMSS_COUNTER -- requirements
Module: mmss_counter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning clk cycles per counted second (>=2).
REQ-002 The block SHALL have parameter MAX_MIN, default 59, meaning the highest minute value, range 1..99.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port init_regs_n, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port count_enabled, input, 1 bit; 1 runs the prescaler, 0 pauses it.
REQ-006 The block SHALL have port count_down, input, 1 bit; 0 counts up, 1 counts down.
REQ-007 The block SHALL have port load, input, 1 bit, meaning a synchronous load strobe for preset.
REQ-008 The block SHALL have port preset, input, 16 bits, meaning the BCD load value {min_tens, min_ones, sec_tens, sec_ones}.
REQ-009 The block SHALL have port lap, input, 1 bit, a synchronous level whose 0->1 transition toggles display hold.
REQ-010 The block SHALL have port time_reading, output, 16 bits, meaning the displayed BCD value in preset's format.
REQ-011 The block SHALL have port tick, output, 1 bit, a one-cycle pulse on each applied step.
REQ-012 The block SHALL have port rollover, output, 1 bit, a one-cycle pulse on an up-mode MAX_MIN:59 -> 00:00 wrap.
REQ-013 The block SHALL have port expired, output, 1 bit, a sticky flag set when a down count reaches 00:00.

Function
REQ-014 The prescaler SHALL count 0..CLK_FREQ-1 while count_enabled=1, hold its value while 0 (pause, not clear), and issue a step on the edge where it wraps from CLK_FREQ-1.
REQ-015 The first step after reset release with count_enabled held at 1 SHALL update the count on the CLK_FREQ-th enabled rising edge.
REQ-016 Up step: sec_ones 9->0 carries into sec_tens; seconds 59->00 carries into minutes; MAX_MIN:59 -> 00:00 with rollover=1 on that step.
REQ-017 Down step: sec_ones 0->9 borrows; seconds 00->59 borrows a minute; 00:01 -> 00:00 sets expired.
REQ-018 While expired=1, steps SHALL be suppressed: count stays 00:00, tick=0, and the prescaler keeps running.
REQ-019 Up mode SHALL never set expired.
REQ-020 A count_down change SHALL take effect at the next step, without clearing the prescaler.
REQ-021 load=1 SHALL take priority over a same-cycle step: count <= preset, prescaler <= 0, expired <= 0, tick = rollover = 0 that cycle.
REQ-022 A preset with any digit >9, sec_tens >5, or minutes >MAX_MIN SHALL load 00:00.
REQ-023 A lap 0->1 edge SHALL toggle hold; while hold=1, time_reading stays at the value captured on that edge while the internal count continues; on release, time_reading shows the live count on the next cycle.
REQ-024 A load SHALL clear hold.
REQ-025 All outputs SHALL be registered, and time_reading SHALL equal the count register on the edge it updates (hold=0).

Reset
REQ-026 init_regs_n=0 SHALL asynchronously force the count, prescaler, hold, lap edge register, tick, rollover and expired to 0, so time_reading=16'h0000, with no clock edge needed.
REQ-027 After release, counting SHALL resume per REQ-015, and a reset asserted mid-second SHALL discard the partial prescaler value.

Verification (CLK_FREQ=10, MAX_MIN=59)
REQ-028 Reset, then enable up for 1200 cycles -> time_reading steps 0001..0059, 0100..0159, 0200 every 10 cycles; one tick per step; rollover never pulses.
REQ-029 Load 16'h5958, up mode, 20 enabled cycles -> 5959, then 0000 with a single rollover pulse on that step.
REQ-030 Load 16'h0002, down mode -> 0001, then 0000 with expired=1; 50 more cycles -> still 0000, no tick; load 16'h0010 clears expired, and the next steps show 0009, 0008.
REQ-031 Deassert count_enabled for 37 cycles at prescaler=4 -> next step is delayed exactly 37 cycles, and the count value is unaffected.
REQ-032 Lap pulse at 0012, wait 30 cycles -> time_reading stays 0012; second lap pulse -> 0015 next cycle; load 16'h0A00 -> 0000.
REQ-033 Assert init_regs_n=0 between clock edges at 0033 -> time_reading=0000 and expired=0 immediately, without waiting for a clock edge.
